// File: rtl/fsm_enc_pkg.sv
// rtl/fsm_enc_pkg.sv - abstract run-controller states and the three state encodings
//
// Holds the abstract state enum, the binary / one-hot / Gray code tables,
// and encode/decode helpers for each. Decoders report whether a code is legal.
// Any unlisted code, including zero-extension garbage, decodes as invalid.

package fsm_enc_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_RUN   = 3'd2,
    ST_WAIT  = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    ENC_BIN  = 2'd0,
    ENC_OH   = 2'd1,
    ENC_GRAY = 2'd2
  } enc_e;

  typedef struct packed {
    logic   valid;
    state_e st;
  } dec_t;

  localparam logic [2:0] BIN_IDLE  = 3'b000;
  localparam logic [2:0] BIN_START = 3'b001;
  localparam logic [2:0] BIN_RUN   = 3'b010;
  localparam logic [2:0] BIN_WAIT  = 3'b011;
  localparam logic [2:0] BIN_DONE  = 3'b100;

  localparam logic [4:0] OH_IDLE   = 5'b00001;
  localparam logic [4:0] OH_START  = 5'b00010;
  localparam logic [4:0] OH_RUN    = 5'b00100;
  localparam logic [4:0] OH_WAIT   = 5'b01000;
  localparam logic [4:0] OH_DONE   = 5'b10000;

  localparam logic [2:0] GRAY_IDLE  = 3'b000;
  localparam logic [2:0] GRAY_START = 3'b001;
  localparam logic [2:0] GRAY_RUN   = 3'b011;
  localparam logic [2:0] GRAY_WAIT  = 3'b010;
  localparam logic [2:0] GRAY_DONE  = 3'b110;

  function automatic logic [2:0] enc_bin(input state_e s);
    case (s)
      ST_START: enc_bin = BIN_START;
      ST_RUN:   enc_bin = BIN_RUN;
      ST_WAIT:  enc_bin = BIN_WAIT;
      ST_DONE:  enc_bin = BIN_DONE;
      default:  enc_bin = BIN_IDLE;
    endcase
  endfunction

  function automatic logic [4:0] enc_oh(input state_e s);
    case (s)
      ST_START: enc_oh = OH_START;
      ST_RUN:   enc_oh = OH_RUN;
      ST_WAIT:  enc_oh = OH_WAIT;
      ST_DONE:  enc_oh = OH_DONE;
      default:  enc_oh = OH_IDLE;
    endcase
  endfunction

  function automatic logic [2:0] enc_gray(input state_e s);
    case (s)
      ST_START: enc_gray = GRAY_START;
      ST_RUN:   enc_gray = GRAY_RUN;
      ST_WAIT:  enc_gray = GRAY_WAIT;
      ST_DONE:  enc_gray = GRAY_DONE;
      default:  enc_gray = GRAY_IDLE;
    endcase
  endfunction

  function automatic dec_t dec_bin(input logic [2:0] c);
    dec_bin = '{valid: 1'b1, st: ST_IDLE};
    case (c)
      BIN_IDLE:  dec_bin.st = ST_IDLE;
      BIN_START: dec_bin.st = ST_START;
      BIN_RUN:   dec_bin.st = ST_RUN;
      BIN_WAIT:  dec_bin.st = ST_WAIT;
      BIN_DONE:  dec_bin.st = ST_DONE;
      default:   dec_bin.valid = 1'b0;
    endcase
  endfunction

  function automatic dec_t dec_oh(input logic [4:0] c);
    dec_oh = '{valid: 1'b1, st: ST_IDLE};
    case (c)
      OH_IDLE:  dec_oh.st = ST_IDLE;
      OH_START: dec_oh.st = ST_START;
      OH_RUN:   dec_oh.st = ST_RUN;
      OH_WAIT:  dec_oh.st = ST_WAIT;
      OH_DONE:  dec_oh.st = ST_DONE;
      default:  dec_oh.valid = 1'b0;
    endcase
  endfunction

  function automatic dec_t dec_gray(input logic [2:0] c);
    dec_gray = '{valid: 1'b1, st: ST_IDLE};
    case (c)
      GRAY_IDLE:  dec_gray.st = ST_IDLE;
      GRAY_START: dec_gray.st = ST_START;
      GRAY_RUN:   dec_gray.st = ST_RUN;
      GRAY_WAIT:  dec_gray.st = ST_WAIT;
      GRAY_DONE:  dec_gray.st = ST_DONE;
      default:    dec_gray.valid = 1'b0;
    endcase
  endfunction

  // Codes are carried zero-extended to 5 bits so one core serves every width.
  function automatic logic [4:0] encode(input enc_e enc, input state_e s);
    case (enc)
      ENC_OH:   encode = enc_oh(s);
      ENC_GRAY: encode = {2'b00, enc_gray(s)};
      default:  encode = {2'b00, enc_bin(s)};
    endcase
  endfunction

  function automatic dec_t decode(input enc_e enc, input logic [4:0] code);
    case (enc)
      ENC_OH:   decode = dec_oh(code);
      ENC_GRAY: decode = dec_gray(code[2:0]);
      default:  decode = dec_bin(code[2:0]);
    endcase
    if (enc != ENC_OH && code[4:3] != 2'b00) decode.valid = 1'b0;
  endfunction

endpackage

// File: rtl/fsm_enc_core.sv
// rtl/fsm_enc_core.sv - one copy of the 5-state run controller in a chosen encoding
//
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   start, stop      begin/resume and pause requests
//   error_in         abort to IDLE
//   force_illegal    load all-ones into the state register at this edge
//   state [SW-1:0]   encoded state register
//   out              registered, high exactly while in RUN

module fsm_enc_core
  import fsm_enc_pkg::*;
#(
  parameter enc_e ENC          = ENC_BIN,
  parameter int   SW           = 3,
  parameter int   RUN_CYCLES   = 8,
  parameter int   WAIT_TIMEOUT = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          stop,
  input  logic          error_in,
  input  logic          force_illegal,
  output logic [SW-1:0] state,
  output logic          out
);

  localparam int RCW = (RUN_CYCLES   > 1) ? $clog2(RUN_CYCLES)   : 1;
  localparam int WCW = (WAIT_TIMEOUT > 1) ? $clog2(WAIT_TIMEOUT) : 1;
  localparam logic [RCW-1:0] RUN_LAST  = RCW'(RUN_CYCLES - 1);
  localparam logic [WCW-1:0] WAIT_LAST = WCW'(WAIT_TIMEOUT - 1);
  localparam logic [SW-1:0]  IDLE_CODE = SW'(encode(ENC, ST_IDLE));

  logic [RCW-1:0] run_cnt, nxt_run;
  logic [WCW-1:0] wait_cnt, nxt_wait;
  dec_t           cur;
  state_e         nxt_st;

  // Next-state logic works on the abstract state; only the register is encoded.
  always_comb begin
    cur      = decode(ENC, 5'(state));
    nxt_st   = cur.st;
    nxt_run  = run_cnt;
    nxt_wait = wait_cnt;
    if (!cur.valid) begin
      nxt_st   = ST_IDLE;
      nxt_run  = '0;
      nxt_wait = '0;
    end else begin
      case (cur.st)
        ST_IDLE: begin
          if (start) begin
            nxt_st  = ST_START;
            nxt_run = '0;
          end
        end
        ST_START: begin
          nxt_st = error_in ? ST_IDLE : ST_RUN;
        end
        ST_RUN: begin
          if (error_in) begin
            nxt_st = ST_IDLE;
          end else if (stop) begin
            nxt_st   = ST_WAIT;
            nxt_wait = '0;
          end else if (run_cnt == RUN_LAST) begin
            nxt_st = ST_DONE;
          end else begin
            nxt_run = run_cnt + RCW'(1);
          end
        end
        ST_WAIT: begin
          // Resume is tested before the timeout so a coinciding start wins.
          if (error_in) begin
            nxt_st = ST_IDLE;
          end else if (start && !stop) begin
            nxt_st = ST_RUN;
          end else if (wait_cnt == WAIT_LAST) begin
            nxt_st = ST_IDLE;
          end else begin
            nxt_wait = wait_cnt + WCW'(1);
          end
        end
        default: nxt_st = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE_CODE;
      out      <= 1'b0;
      run_cnt  <= '0;
      wait_cnt <= '0;
    end else begin
      run_cnt  <= nxt_run;
      wait_cnt <= nxt_wait;
      if (force_illegal) begin
        state <= '1;
        out   <= 1'b0;
      end else begin
        state <= SW'(encode(ENC, nxt_st));
        out   <= (nxt_st == ST_RUN);
      end
    end
  end

endmodule

// File: rtl/fsm_encoding_triplet.sv
// rtl/fsm_encoding_triplet.sv - binary, one-hot and Gray copies of one run controller
//
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   start, stop, error_in       shared controller inputs
//   fault_inj                   corrupt the Gray copy to 3'b111 at this edge
//   state_binary, out_binary    binary copy (3-bit state)
//   state_onehot, out_onehot    one-hot copy (5-bit state)
//   state_gray,   out_gray      Gray copy (3-bit state)

module fsm_encoding_triplet
  import fsm_enc_pkg::*;
#(
  parameter int RUN_CYCLES   = 8,
  parameter int WAIT_TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       stop,
  input  logic       error_in,
  input  logic       fault_inj,
  output logic [2:0] state_binary,
  output logic       out_binary,
  output logic [4:0] state_onehot,
  output logic       out_onehot,
  output logic [2:0] state_gray,
  output logic       out_gray
);

  fsm_enc_core #(
    .ENC(ENC_BIN), .SW(3), .RUN_CYCLES(RUN_CYCLES), .WAIT_TIMEOUT(WAIT_TIMEOUT)
  ) u_bin (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .error_in(error_in),
    .force_illegal(1'b0), .state(state_binary), .out(out_binary)
  );

  fsm_enc_core #(
    .ENC(ENC_OH), .SW(5), .RUN_CYCLES(RUN_CYCLES), .WAIT_TIMEOUT(WAIT_TIMEOUT)
  ) u_oh (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .error_in(error_in),
    .force_illegal(1'b0), .state(state_onehot), .out(out_onehot)
  );

  fsm_enc_core #(
    .ENC(ENC_GRAY), .SW(3), .RUN_CYCLES(RUN_CYCLES), .WAIT_TIMEOUT(WAIT_TIMEOUT)
  ) u_gray (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .error_in(error_in),
    .force_illegal(fault_inj), .state(state_gray), .out(out_gray)
  );

endmodule

// File: tb/tb_fsm_encoding_triplet.sv
// tb/tb_fsm_encoding_triplet.sv - directed self-checking bench for fsm_encoding_triplet

module tb_fsm_encoding_triplet;

  localparam int I = 0, S = 1, R = 2, W = 3, D = 4;

  localparam logic [2:0] BINC  [5] = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b100};
  localparam logic [4:0] OHC   [5] = '{5'b00001, 5'b00010, 5'b00100, 5'b01000, 5'b10000};
  localparam logic [2:0] GRAYC [5] = '{3'b000, 3'b001, 3'b011, 3'b010, 3'b110};

  logic       clk = 1'b0;
  logic       rst, start, stop, error_in, fault_inj;
  logic [2:0] state_binary, state_gray;
  logic [4:0] state_onehot;
  logic       out_binary, out_onehot, out_gray;

  int checks = 0;
  int errors = 0;

  fsm_encoding_triplet #(.RUN_CYCLES(4), .WAIT_TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .error_in(error_in),
    .fault_inj(fault_inj),
    .state_binary(state_binary), .out_binary(out_binary),
    .state_onehot(state_onehot), .out_onehot(out_onehot),
    .state_gray(state_gray), .out_gray(out_gray)
  );

  always #5 clk = ~clk;

  task automatic step(input logic s, input logic p, input logic e, input logic f);
    start = s; stop = p; error_in = e; fault_inj = f;
    @(posedge clk);
    #1;
  endtask

  task automatic chkx(input string tag, input int st, input logic [2:0] gexp, input logic gout);
    logic rexp;
    rexp = (st == R);
    checks++;
    assert (state_binary === BINC[st]) else begin
      errors++; $error("FAIL %s state_binary got %b exp %b", tag, state_binary, BINC[st]);
    end
    checks++;
    assert (state_onehot === OHC[st]) else begin
      errors++; $error("FAIL %s state_onehot got %b exp %b", tag, state_onehot, OHC[st]);
    end
    checks++;
    assert (state_gray === gexp) else begin
      errors++; $error("FAIL %s state_gray got %b exp %b", tag, state_gray, gexp);
    end
    checks++;
    assert (out_binary === rexp) else begin
      errors++; $error("FAIL %s out_binary got %b exp %b", tag, out_binary, rexp);
    end
    checks++;
    assert (out_onehot === rexp) else begin
      errors++; $error("FAIL %s out_onehot got %b exp %b", tag, out_onehot, rexp);
    end
    checks++;
    assert (out_gray === gout) else begin
      errors++; $error("FAIL %s out_gray got %b exp %b", tag, out_gray, gout);
    end
  endtask

  task automatic chk(input string tag, input int st);
    chkx(tag, st, GRAYC[st], st == R);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; stop = 1'b0; error_in = 1'b0; fault_inj = 1'b0;

    // Reset for two cycles; fault_inj during reset must not reach the Gray copy.
    step(0, 0, 0, 0);
    step(1, 0, 0, 1);
    chk("reset", I);
    rst = 1'b0;
    step(0, 0, 0, 0); chk("idle_hold", I);

    // Full run, start pulsed.
    step(1, 0, 0, 0); chk("run_e0", S);
    for (int k = 1; k <= 4; k++) begin
      step(0, 0, 0, 0); chk($sformatf("run_e%0d", k), R);
    end
    step(0, 0, 0, 0); chk("run_done", D);
    step(0, 0, 0, 0); chk("run_idle", I);

    // start held through DONE: IDLE first, then re-trigger.
    step(1, 0, 0, 0); chk("held_e0", S);
    for (int k = 1; k <= 4; k++) begin
      step(1, 0, 0, 0); chk($sformatf("held_e%0d", k), R);
    end
    step(1, 0, 0, 0); chk("held_done", D);
    step(1, 0, 0, 0); chk("held_idle", I);
    step(1, 0, 0, 0); chk("held_restart", S);
    step(1, 0, 0, 0); chk("held_run0", R);
    step(0, 0, 0, 0); chk("held_run1", R);

    // Abort with everything high in RUN.
    step(1, 1, 1, 0); chk("abort", I);

    // Pause/resume: 3 RUN cycles, stop sampled 3 times, resume, 2 more RUN.
    step(1, 0, 0, 0); chk("pause_start", S);
    step(0, 0, 0, 0); chk("pause_r0", R);
    step(0, 0, 0, 0); chk("pause_r1", R);
    step(0, 0, 0, 0); chk("pause_r2", R);
    step(0, 1, 0, 0); chk("pause_w0", W);
    step(1, 1, 0, 0); chk("pause_w1_stopwins", W);
    step(0, 1, 0, 0); chk("pause_w2", W);
    step(1, 0, 0, 0); chk("resume_r3", R);
    step(0, 0, 0, 0); chk("resume_r4", R);
    step(0, 0, 0, 0); chk("pause_done", D);
    step(0, 0, 0, 0); chk("pause_idle", I);

    // Error in START.
    step(1, 0, 0, 0); chk("err_start0", S);
    step(0, 0, 1, 0); chk("err_start1", I);

    // Timeout: 16 WAIT cycles then IDLE.
    step(1, 0, 0, 0); chk("to_start", S);
    step(0, 0, 0, 0); chk("to_run", R);
    step(0, 1, 0, 0); chk("to_w0", W);
    for (int k = 1; k <= 15; k++) begin
      step(0, 0, 0, 0); chk($sformatf("to_w%0d", k), W);
    end
    step(0, 0, 0, 0); chk("to_idle", I);

    // Resume coinciding with the timeout edge.
    step(1, 0, 0, 0); chk("tr_start", S);
    step(0, 0, 0, 0); chk("tr_run", R);
    step(0, 1, 0, 0); chk("tr_w0", W);
    for (int k = 1; k <= 15; k++) begin
      step(0, 0, 0, 0); chk($sformatf("tr_w%0d", k), W);
    end
    step(1, 0, 0, 0); chk("tr_resume", R);
    step(0, 0, 1, 0); chk("tr_abort", I);

    // Fault injection in RUN: Gray goes 111 then recovers to IDLE.
    step(1, 0, 0, 0); chk("f_start", S);
    step(0, 0, 0, 0); chk("f_r0", R);
    step(0, 0, 0, 0); chk("f_r1", R);
    step(0, 0, 0, 1); chkx("f_inject", R, 3'b111, 1'b0);
    step(0, 0, 0, 0); chkx("f_recover", R, 3'b000, 1'b0);
    step(0, 0, 0, 0); chkx("f_done", D, 3'b000, 1'b0);
    step(0, 0, 0, 0); chk("f_idle", I);

    // Reset in the middle of RUN overrides fault_inj.
    step(1, 0, 0, 0); chk("rr_start", S);
    step(0, 0, 0, 0); chk("rr_run", R);
    rst = 1'b1;
    step(1, 0, 0, 1); chk("rr_reset", I);
    rst = 1'b0;
    step(0, 0, 0, 0); chk("rr_idle", I);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
